branch_pc_controller: RTL
=========================

# branch_pc_controller

Fetch-stage PC sequencer with a direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction predictor. Owns the fetch PC register. Each cycle it selects the next PC from sequential, predicted-taken or EX-resolved redirect, and raises a flush on mispredict. Sits between instruction memory and the IF/ID register, and takes branch resolution from EX.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- IDX_BITS, 4, log2 of BTB entries (16 entries)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; hold PC when no redirect
- ex_valid  in  1  EX stage holds a valid instruction this cycle
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_taken  in  1  resolved direction
- ex_pc  in  32  PC of EX instruction
- ex_target  in  32  resolved target (ex_pc + imm)
- ex_pred_taken  in  1  prediction made at fetch, piped to EX
- ex_pred_target  in  32  predicted target, piped to EX
- pc  out  32  current fetch PC (registered)
- pc_src  out  2  next-PC source: 00 pc+4, 01 EX redirect, 10 BTB prediction, 11 hold (stall)
- pred_taken  out  1  prediction for current pc (pipe to EX)
- pred_target  out  32  BTB target for current pc (pipe to EX)
- flush  out  1  kill IF/ID and ID/EX this cycle

## Operation
- BTB entry: valid, tag = pc[31:IDX_BITS+2], target[31:0], ctr[1:0]. Index = pc[IDX_BITS+1:2].
- Lookup (combinational on pc): hit = valid && tag match. pred_taken = hit && ctr[1]. pred_target = entry target (0 when !hit).
- mispredict = ex_valid && ((ex_is_branch && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target))) || (!ex_is_branch && ex_pred_taken)).
- Next-PC priority: rst > mispredict > stall > pred_taken > sequential.
  - mispredict: pc <= ex_taken&&ex_is_branch ? ex_target : ex_pc+4. pc_src=01. flush=1. Overrides stall.
  - stall: pc held, pc_src=11.
  - pred_taken: pc <= pred_target, pc_src=10.
  - else pc <= pc+4, pc_src=00.
- All PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Update, at the edge when ex_valid && ex_is_branch, indexed by ex_pc:
  - Hit: ctr increments on taken, decrements on not-taken, saturating at 11/00. Target is overwritten with ex_target when taken.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target=ex_target, ctr=10.
  - Miss and not taken: no change.
- Non-branch with ex_pred_taken (alias): invalidate the entry if its tag matches ex_pc.
- Lookup and update in the same cycle to the same entry: lookup returns pre-update contents. The new value is visible the next cycle.
- Updates occur regardless of stall.

## Timing
- Reset (rst high at an edge):
  - pc=RESET_PC.
  - All valid=0 and all ctr=01.
  - While rst is high, flush=0 and pc_src=00. Table updates are suppressed.
  - Reset mid-redirect discards the redirect.
- pc_src, flush, pred_taken and pred_target are combinational in the current cycle. pc changes at the next edge.
- Redirect latency is 1 cycle: flush is asserted in the EX-resolution cycle, and the corrected PC is fetched in the following cycle.
- flush is a single-cycle pulse per mispredicting EX instruction. The upstream stage must present each ex_valid instruction for one cycle only.

## Configuration
- BP_PREDICT_EN defined: full behaviour as above.
- BP_PREDICT_EN undefined:
  - No BTB storage is built; pred_taken=0 and pred_target=0 always.
  - pc_src is never 10.
  - Every taken branch mispredicts and redirects via EX; not-taken branches never flush.

## Test plan
- rst for 2 cycles with RESET_PC=32'h100 -> pc=0x100, flush=0. Then 3 free cycles -> pc 0x104, 0x108, 0x10C, pc_src=00.
- EX taken branch at ex_pc=0x104, ex_target=0x200, ex_pred_taken=0 -> flush=1, pc_src=01, next pc=0x200. Later fetch at 0x104 -> pred_taken=1, pred_target=0x200, pc_src=10.
- Same branch resolved not-taken twice after allocation -> ctr 10→01→00. Second resolution: ex_pred_taken=1 -> flush, next pc=0x108. Subsequent lookup gives pred_taken=0.
- stall=1 for 3 cycles at pc=0x10C -> pc held, pc_src=11. Mispredict arriving during the stall -> redirect taken immediately, flush=1.
- Two branches aliasing index (0x104, 0x144 with IDX_BITS=4) -> second taken allocation evicts first. Lookup at 0x104 misses.
- pc=32'hFFFF_FFFC, no prediction -> next pc=0. Non-branch at EX with ex_pred_taken=1 -> flush, redirect ex_pc+4, entry invalidated.

Source files
------------

// File: rtl/branch_pc_controller.sv
// Fetch-stage PC sequencer: owns the fetch PC, picks the next PC and flushes on EX mispredict.
// Optional macro BP_PREDICT_EN builds the direct-mapped BTB / 2-bit predictor; otherwise fetch never predicts taken.

module branch_pc_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc,
  output logic [1:0]  pc_src,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush
);

  logic [31:0] pc_r;
  logic [31:0] next_pc_s;
  logic [31:0] seq_pc_s;
  logic [31:0] redirect_pc_s;
  logic        mispredict_s;
  logic        pred_taken_s;
  logic [31:0] pred_target_s;
  logic [1:0]  pc_src_s;
  logic        flush_s;

  assign seq_pc_s      = pc_r + 32'd4;
  assign redirect_pc_s = (ex_taken && ex_is_branch) ? ex_target : (ex_pc + 32'd4);
  assign mispredict_s  = ex_valid &&
                         ((ex_is_branch && ((ex_taken != ex_pred_taken) ||
                                            (ex_taken && (ex_target != ex_pred_target)))) ||
                          (!ex_is_branch && ex_pred_taken));

`ifdef BP_PREDICT_EN
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic                btb_valid_r  [ENTRIES];
  logic [TAG_W-1:0]    btb_tag_r    [ENTRIES];
  logic [31:0]         btb_target_r [ENTRIES];
  logic [1:0]          btb_ctr_r    [ENTRIES];

  logic [IDX_BITS-1:0] lk_idx_s;
  logic [TAG_W-1:0]    lk_tag_s;
  logic                lk_hit_s;
  logic [IDX_BITS-1:0] up_idx_s;
  logic [TAG_W-1:0]    up_tag_s;
  logic                up_tag_match_s;
  logic                up_hit_s;

  assign lk_idx_s       = pc_r[IDX_BITS+1:2];
  assign lk_tag_s       = pc_r[31:IDX_BITS+2];
  assign lk_hit_s       = btb_valid_r[lk_idx_s] && (btb_tag_r[lk_idx_s] == lk_tag_s);
  assign up_idx_s       = ex_pc[IDX_BITS+1:2];
  assign up_tag_s       = ex_pc[31:IDX_BITS+2];
  assign up_tag_match_s = (btb_tag_r[up_idx_s] == up_tag_s);
  assign up_hit_s       = btb_valid_r[up_idx_s] && up_tag_match_s;

  // BTB lookup on the current fetch PC (sees pre-update contents)
  always_comb begin
    pred_taken_s  = 1'b0;
    pred_target_s = 32'd0;
    if (lk_hit_s) begin
      pred_taken_s  = btb_ctr_r[lk_idx_s][1];
      pred_target_s = btb_target_r[lk_idx_s];
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = 32'd0;
    end
  end

  // BTB training from EX resolution; runs even while fetch is stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_valid_r[i] <= 1'b0;
        btb_ctr_r[i]   <= 2'b01;
      end
    end else if (ex_valid && ex_is_branch) begin
      if (up_hit_s) begin
        if (ex_taken) begin
          if (btb_ctr_r[up_idx_s] != 2'b11) begin
            btb_ctr_r[up_idx_s] <= btb_ctr_r[up_idx_s] + 2'd1;
          end
          btb_target_r[up_idx_s] <= ex_target;
        end else if (btb_ctr_r[up_idx_s] != 2'b00) begin
          btb_ctr_r[up_idx_s] <= btb_ctr_r[up_idx_s] - 2'd1;
        end
      end else if (ex_taken) begin
        btb_valid_r[up_idx_s]  <= 1'b1;
        btb_tag_r[up_idx_s]    <= up_tag_s;
        btb_target_r[up_idx_s] <= ex_target;
        btb_ctr_r[up_idx_s]    <= 2'b10;
      end
    end else if (ex_valid && ex_pred_taken && up_tag_match_s) begin
      // a non-branch was predicted taken: the entry is an alias, drop it
      btb_valid_r[up_idx_s] <= 1'b0;
    end
  end
`else
  assign pred_taken_s  = 1'b0;
  assign pred_target_s = 32'd0;
`endif

  // Next-PC select: reset > EX redirect > stall > predicted taken > sequential
  always_comb begin
    next_pc_s = seq_pc_s;
    pc_src_s  = 2'b00;
    flush_s   = 1'b0;
    if (rst) begin
      next_pc_s = RESET_PC;
      pc_src_s  = 2'b00;
      flush_s   = 1'b0;
    end else if (mispredict_s) begin
      next_pc_s = redirect_pc_s;
      pc_src_s  = 2'b01;
      flush_s   = 1'b1;
    end else if (stall) begin
      next_pc_s = pc_r;
      pc_src_s  = 2'b11;
      flush_s   = 1'b0;
    end else if (pred_taken_s) begin
      next_pc_s = pred_target_s;
      pc_src_s  = 2'b10;
      flush_s   = 1'b0;
    end else begin
      next_pc_s = seq_pc_s;
      pc_src_s  = 2'b00;
      flush_s   = 1'b0;
    end
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= next_pc_s;
    end
  end

  assign pc          = pc_r;
  assign pc_src      = pc_src_s;
  assign flush       = flush_s;
  assign pred_taken  = pred_taken_s;
  assign pred_target = pred_target_s;

endmodule
